// File: rtl/ray_bounce_ctrl_if.sv
// ray_bounce_ctrl_if: ray intake, intersector, reflector and pixel handshakes of the bounce controller
interface ray_bounce_ctrl_if;
  logic [71:0] ray_in_origin;
  logic [71:0] ray_in_dir;
  logic [71:0] ray_in_color;
  logic [71:0] ray_in_light;
  logic [47:0] ray_in_seed;
  logic        ray_in_valid;
  logic        ray_in_ready;
  logic [71:0] isect_origin;
  logic [71:0] isect_dir;
  logic        isect_start;
  logic        isect_done;
  logic        isect_hit;
  logic        refl_start;
  logic [71:0] cur_dir;
  logic [71:0] cur_color;
  logic [71:0] cur_light;
  logic [47:0] lfsr_seed;
  logic [71:0] new_dir;
  logic [71:0] new_origin;
  logic [71:0] new_color;
  logic [71:0] new_income_light;
  logic        reflect_done;
  logic [71:0] pixel_color;
  logic [3:0]  pixel_bounces;
  logic        pixel_err;
  logic        pixel_valid;
  logic        pixel_ready;
  modport master (
    input  ray_in_origin, ray_in_dir, ray_in_color, ray_in_light, ray_in_seed, ray_in_valid,
    input  isect_done, isect_hit,
    input  new_dir, new_origin, new_color, new_income_light, reflect_done,
    input  pixel_ready,
    output ray_in_ready, isect_origin, isect_dir, isect_start, refl_start,
    output cur_dir, cur_color, cur_light, lfsr_seed,
    output pixel_color, pixel_bounces, pixel_err, pixel_valid
  );
  modport slave (
    output ray_in_origin, ray_in_dir, ray_in_color, ray_in_light, ray_in_seed, ray_in_valid,
    output isect_done, isect_hit,
    output new_dir, new_origin, new_color, new_income_light, reflect_done,
    output pixel_ready,
    input  ray_in_ready, isect_origin, isect_dir, isect_start, refl_start,
    input  cur_dir, cur_color, cur_light, lfsr_seed,
    input  pixel_color, pixel_bounces, pixel_err, pixel_valid
  );
endinterface

// File: rtl/ray_bounce_ctrl.sv
// ray_bounce_ctrl: walks one ray path through intersect/reflect rounds up to MAX_BOUNCES, with a per-wait watchdog
module ray_bounce_ctrl #(
  parameter int MAX_BOUNCES    = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic               clk,
  input logic               rst,
  ray_bounce_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, TRACE, WAIT_ISECT, WAIT_REFLECT, OUTPUT} state_t;
  localparam logic [3:0] BNC_LAST = 4'(MAX_BOUNCES - 1);
  localparam logic [9:0] WD_LAST  = 10'(TIMEOUT_CYCLES - 1);
  state_t      r_state;
  state_t      w_next;
  logic [71:0] r_origin;
  logic [71:0] r_dir;
  logic [71:0] r_color;
  logic [71:0] r_light;
  logic [47:0] r_seed;
  logic [3:0]  r_bnc;
  logic [9:0]  r_wd;
  logic        r_err;
  logic        w_accept;
  logic        w_waiting;
  logic        w_hit;
  logic        w_miss;
  logic        w_refl;
  logic        w_expire;
  always_comb begin
    w_accept  = r_state == IDLE && bus.ray_in_valid;
    w_waiting = r_state == WAIT_ISECT || r_state == WAIT_REFLECT;
    w_hit     = r_state == WAIT_ISECT && bus.isect_done && bus.isect_hit;
    w_miss    = r_state == WAIT_ISECT && bus.isect_done && !bus.isect_hit;
    w_refl    = r_state == WAIT_REFLECT && bus.reflect_done;
    // a strobe landing on the expiry cycle wins over the timeout
    w_expire  = w_waiting && r_wd == WD_LAST && !(w_hit || w_miss || w_refl);
    w_next    = r_state;
    case (r_state)
      IDLE:         w_next = w_accept ? TRACE : IDLE;
      TRACE:        w_next = WAIT_ISECT;
      WAIT_ISECT:   w_next = w_hit ? WAIT_REFLECT : (w_miss || w_expire) ? OUTPUT : WAIT_ISECT;
      WAIT_REFLECT: w_next = w_refl ? (r_bnc == BNC_LAST ? OUTPUT : TRACE) : w_expire ? OUTPUT : WAIT_REFLECT;
      OUTPUT:       w_next = bus.pixel_ready ? IDLE : OUTPUT;
      default:      w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_origin <= '0;
      r_dir    <= '0;
      r_color  <= '0;
      r_light  <= '0;
      r_seed   <= '0;
      r_bnc    <= '0;
      r_wd     <= '0;
      r_err    <= 1'b0;
    end else begin
      r_wd <= (w_waiting && w_next == r_state) ? r_wd + 10'd1 : '0;
      if (w_accept) begin
        r_origin <= bus.ray_in_origin;
        r_dir    <= bus.ray_in_dir;
        r_color  <= bus.ray_in_color;
        r_light  <= bus.ray_in_light;
        r_seed   <= bus.ray_in_seed;
        r_bnc    <= '0;
        r_err    <= 1'b0;
      end
      if (w_refl) begin
        r_origin <= bus.new_origin;
        r_dir    <= bus.new_dir;
        r_color  <= bus.new_color;
        r_light  <= bus.new_income_light;
        r_bnc    <= r_bnc + 4'd1;
      end
      if (w_expire) r_err <= 1'b1;
    end
  end
  assign bus.ray_in_ready  = r_state == IDLE;
  assign bus.isect_origin  = r_origin;
  assign bus.isect_dir     = r_dir;
  assign bus.isect_start   = r_state == TRACE;
  assign bus.refl_start    = w_hit;
  assign bus.cur_dir       = r_dir;
  assign bus.cur_color     = r_color;
  assign bus.cur_light     = r_light;
  assign bus.lfsr_seed     = r_seed + 48'(r_bnc);
  assign bus.pixel_color   = r_light;
  assign bus.pixel_bounces = r_bnc;
  assign bus.pixel_err     = r_err;
  assign bus.pixel_valid   = r_state == OUTPUT;
endmodule

// File: tb/tb_ray_bounce_ctrl.sv
// tb_ray_bounce_ctrl: randomized paths checked against a path-level model of bounce count, light and seeds
module tb_ray_bounce_ctrl;
  localparam int MAXB = 4;
  localparam int TO   = 16;
  logic clk;
  logic rst;
  int checks;
  int failures;
  int mon_isect;
  int mon_refl;
  ray_bounce_ctrl_if bus ();
  ray_bounce_ctrl #(.MAX_BOUNCES(MAXB), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [71:0] st_origin, st_dir, st_color, st_light;
  logic [47:0] st_seed;
  logic [71:0] st_ndir [16];
  logic [71:0] st_norigin [16];
  logic [71:0] st_ncolor [16];
  logic [71:0] st_nlight [16];
  logic [71:0] obs_idir [16];
  logic [71:0] obs_iorigin [16];
  logic [71:0] obs_cdir [16];
  logic [71:0] obs_clight [16];
  logic [47:0] obs_seed [16];
  logic        obs_rcomb [16];
  int          obs_traces, obs_refls, obs_wait;
  logic [71:0] obs_pcolor;
  logic [3:0]  obs_pbnc;
  logic        obs_perr;
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.isect_start) mon_isect <= mon_isect + 1;
    if (bus.refl_start) mon_refl <= mon_refl + 1;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [71:0] r72();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[71:0];
  endfunction
  task automatic rand_path();
    logic [63:0] s;
    s = {$urandom(), $urandom()};
    st_origin = r72();
    st_dir    = r72();
    st_color  = r72();
    st_light  = r72();
    st_seed   = ($urandom_range(3, 0) == 0) ? 48'hFFFF_FFFF_FFFE : s[47:0];
    for (int i = 0; i < 16; i++) begin
      st_ndir[i]    = r72();
      st_norigin[i] = r72();
      st_ncolor[i]  = r72();
      st_nlight[i]  = r72();
    end
  endtask
  task automatic pop();
    bus.pixel_ready = 1;
    step();
    bus.pixel_ready = 0;
  endtask
  // acts as intersector/reflector: first `hits` requests hit, later ones miss (or go unanswered when no_resp)
  task automatic drive_path(input int hits, input int i_lat, input int r_lat, input bit no_resp, output bit ok);
    int w;
    ok = 1;
    obs_traces = 0;
    obs_refls = 0;
    obs_wait = 0;
    bus.ray_in_origin = st_origin;
    bus.ray_in_dir = st_dir;
    bus.ray_in_color = st_color;
    bus.ray_in_light = st_light;
    bus.ray_in_seed = st_seed;
    bus.ray_in_valid = 1;
    step();
    bus.ray_in_valid = 0;
    forever begin
      w = 0;
      while (!bus.isect_start && !bus.pixel_valid && w < 40) begin step(); w++; end
      if (!bus.isect_start && !bus.pixel_valid) begin ok = 0; break; end
      if (bus.pixel_valid) break;
      obs_idir[obs_traces] = bus.isect_dir;
      obs_iorigin[obs_traces] = bus.isect_origin;
      step();
      if (no_resp && obs_traces == hits) begin
        w = 0;
        while (!bus.pixel_valid && w < 40) begin step(); w++; end
        obs_wait = w;
        obs_traces++;
        break;
      end
      repeat (i_lat) step();
      bus.isect_done = 1;
      bus.isect_hit = obs_traces < hits;
      #1;
      obs_rcomb[obs_traces] = bus.refl_start;
      obs_seed[obs_traces] = bus.lfsr_seed;
      obs_cdir[obs_traces] = bus.cur_dir;
      obs_clight[obs_traces] = bus.cur_light;
      obs_traces++;
      step();
      bus.isect_done = 0;
      bus.isect_hit = 0;
      if (obs_traces > hits) break;
      repeat (r_lat) step();
      bus.new_dir = st_ndir[obs_refls];
      bus.new_origin = st_norigin[obs_refls];
      bus.new_color = st_ncolor[obs_refls];
      bus.new_income_light = st_nlight[obs_refls];
      bus.reflect_done = 1;
      step();
      bus.reflect_done = 0;
      obs_refls++;
    end
    w = 0;
    while (!bus.pixel_valid && w < 40) begin step(); w++; end
    if (!bus.pixel_valid) ok = 0;
    obs_pcolor = bus.pixel_color;
    obs_pbnc = bus.pixel_bounces;
    obs_perr = bus.pixel_err;
  endtask
  task automatic test_reset();
    rst = 1;
    step();
    step();
    rst = 0;
    step();
    checks++;
    if (bus.ray_in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ray_in_ready); end
    checks++;
    if ({bus.isect_start, bus.refl_start, bus.pixel_valid, bus.pixel_err, bus.pixel_bounces, bus.pixel_color,
         bus.lfsr_seed, bus.isect_dir, bus.isect_origin, bus.cur_dir, bus.cur_color, bus.cur_light} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {bus.pixel_color, bus.lfsr_seed, bus.cur_light});
    end
  endtask
  task automatic test_miss();
    bit ok;
    int mi, mr;
    rand_path();
    mi = mon_isect;
    mr = mon_refl;
    drive_path(0, 5, 0, 0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL miss_done got=timeout exp=pixel_valid"); end
    checks++;
    if (obs_pcolor !== st_light) begin failures++; $display("FAIL miss_color got=%h exp=%h", obs_pcolor, st_light); end
    checks++;
    if (obs_pbnc !== 4'd0 || obs_perr !== 1'b0) begin failures++; $display("FAIL miss_bnc_err got=%0d/%b exp=0/0", obs_pbnc, obs_perr); end
    checks++;
    if (mon_isect - mi != 1 || mon_refl - mr != 0) begin failures++; $display("FAIL miss_pulses got=%0d/%0d exp=1/0", mon_isect - mi, mon_refl - mr); end
    checks++;
    if (obs_idir[0] !== st_dir || obs_iorigin[0] !== st_origin) begin failures++; $display("FAIL miss_isect_ray got=%h exp=%h", obs_idir[0], st_dir); end
    pop();
    checks++;
    if (bus.ray_in_ready !== 1'b1) begin failures++; $display("FAIL miss_idle got=%b exp=1", bus.ray_in_ready); end
  endtask
  task automatic test_all_hits();
    bit ok;
    int mr;
    logic [47:0] es;
    logic [71:0] ed, el;
    rand_path();
    mr = mon_refl;
    drive_path(MAXB + 2, $urandom_range(6, 0), $urandom_range(6, 0), 0, ok);
    checks++;
    if (!ok || mon_refl - mr != MAXB) begin failures++; $display("FAIL hits_refl_pulses got=%0d exp=%0d", mon_refl - mr, MAXB); end
    for (int k = 0; k < MAXB; k++) begin
      es = st_seed + 48'(k);
      ed = (k == 0) ? st_dir : st_ndir[k - 1];
      el = (k == 0) ? st_light : st_nlight[k - 1];
      checks++;
      if (obs_rcomb[k] !== 1'b1 || obs_seed[k] !== es) begin failures++; $display("FAIL hits_seed%0d got=%h exp=%h", k, obs_seed[k], es); end
      checks++;
      if (obs_cdir[k] !== ed || obs_clight[k] !== el) begin failures++; $display("FAIL hits_cur%0d got=%h exp=%h", k, obs_cdir[k], ed); end
    end
    checks++;
    if (obs_pbnc !== 4'(MAXB) || obs_perr !== 1'b0) begin failures++; $display("FAIL hits_bnc got=%0d exp=%0d", obs_pbnc, MAXB); end
    checks++;
    if (obs_pcolor !== st_nlight[MAXB - 1]) begin failures++; $display("FAIL hits_color got=%h exp=%h", obs_pcolor, st_nlight[MAXB - 1]); end
    pop();
  endtask
  task automatic test_hit_hit_miss();
    bit ok;
    int mi;
    rand_path();
    mi = mon_isect;
    drive_path(2, $urandom_range(4, 0), $urandom_range(4, 0), 0, ok);
    checks++;
    if (!ok || obs_pbnc !== 4'd2) begin failures++; $display("FAIL hhm_bnc got=%0d exp=2", obs_pbnc); end
    checks++;
    if (obs_idir[2] !== st_ndir[1] || obs_iorigin[2] !== st_norigin[1]) begin failures++; $display("FAIL hhm_dir3 got=%h exp=%h", obs_idir[2], st_ndir[1]); end
    checks++;
    if (obs_pcolor !== st_nlight[1] || mon_isect - mi != 3) begin failures++; $display("FAIL hhm_color got=%h exp=%h", obs_pcolor, st_nlight[1]); end
    pop();
  endtask
  task automatic test_random();
    bit ok;
    int h, b;
    logic [71:0] ec, ed;
    for (int n = 0; n < 8; n++) begin
      rand_path();
      h = $urandom_range(6, 0);
      drive_path(h, $urandom_range(14, 0), $urandom_range(14, 0), 0, ok);
      b = (h < MAXB) ? h : MAXB;
      ec = (b == 0) ? st_light : st_nlight[b - 1];
      checks++;
      if (!ok || obs_pbnc !== 4'(b) || obs_perr !== 1'b0) begin failures++; $display("FAIL rand%0d_bnc got=%0d exp=%0d", n, obs_pbnc, b); end
      checks++;
      if (obs_pcolor !== ec) begin failures++; $display("FAIL rand%0d_color got=%h exp=%h", n, obs_pcolor, ec); end
      for (int k = 0; k < obs_traces; k++) begin
        ed = (k == 0) ? st_dir : st_ndir[k - 1];
        checks++;
        if (obs_idir[k] !== ed) begin failures++; $display("FAIL rand%0d_dir%0d got=%h exp=%h", n, k, obs_idir[k], ed); end
      end
      pop();
    end
  endtask
  task automatic test_watchdog();
    bit ok;
    rand_path();
    drive_path(0, 0, 0, 1, ok);
    checks++;
    if (obs_wait != TO) begin failures++; $display("FAIL wd_latency got=%0d exp=%0d", obs_wait, TO); end
    checks++;
    if (obs_perr !== 1'b1 || obs_pbnc !== 4'd0 || obs_pcolor !== st_light) begin failures++; $display("FAIL wd_pixel got=%b/%0d exp=1/0", obs_perr, obs_pbnc); end
    pop();
    rand_path();
    drive_path(0, TO - 1, 0, 0, ok);
    checks++;
    if (!ok || obs_perr !== 1'b0 || obs_pcolor !== st_light) begin failures++; $display("FAIL wd_isect_edge got=%b exp=0", obs_perr); end
    pop();
    rand_path();
    drive_path(1, 3, TO - 1, 0, ok);
    checks++;
    if (!ok || obs_perr !== 1'b0 || obs_pbnc !== 4'd1 || obs_pcolor !== st_nlight[0]) begin
      failures++;
      $display("FAIL wd_refl_edge got=%b/%0d exp=0/1", obs_perr, obs_pbnc);
    end
    pop();
  endtask
  task automatic test_backpressure();
    bit ok;
    rand_path();
    drive_path(1, 2, 2, 0, ok);
    bus.ray_in_valid = 1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (!ok || bus.pixel_valid !== 1'b1 || bus.ray_in_ready !== 1'b0 || bus.pixel_color !== st_nlight[0] ||
          bus.pixel_bounces !== 4'd1 || bus.pixel_err !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d got=%b/%b/%h exp=1/0/%h", c, bus.pixel_valid, bus.ray_in_ready, bus.pixel_color, st_nlight[0]);
      end
      step();
    end
    bus.pixel_ready = 1;
    #1;
    checks++;
    if (bus.ray_in_ready !== 1'b0) begin failures++; $display("FAIL bp_pop_ready got=%b exp=0", bus.ray_in_ready); end
    step();
    bus.pixel_ready = 0;
    bus.ray_in_valid = 0;
    checks++;
    if (bus.ray_in_ready !== 1'b1 || bus.isect_start !== 1'b0 || bus.pixel_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_accept got=%b/%b exp=1/0", bus.ray_in_ready, bus.isect_start);
    end
    step();
  endtask
  task automatic test_reset_mid();
    rand_path();
    bus.ray_in_origin = st_origin;
    bus.ray_in_dir = st_dir;
    bus.ray_in_color = st_color;
    bus.ray_in_light = st_light;
    bus.ray_in_seed = st_seed;
    bus.ray_in_valid = 1;
    step();
    bus.ray_in_valid = 0;
    step();
    bus.isect_done = 1;
    bus.isect_hit = 1;
    step();
    bus.isect_done = 0;
    bus.isect_hit = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    bus.new_dir = st_ndir[0];
    bus.new_origin = st_norigin[0];
    bus.new_color = st_ncolor[0];
    bus.new_income_light = st_nlight[0];
    bus.reflect_done = 1;
    bus.isect_done = 1;
    step();
    step();
    bus.reflect_done = 0;
    bus.isect_done = 0;
    checks++;
    if (bus.ray_in_ready !== 1'b1 || bus.isect_start !== 1'b0 || bus.pixel_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_state got=%b/%b/%b exp=1/0/0", bus.ray_in_ready, bus.isect_start, bus.pixel_valid);
    end
    checks++;
    if ({bus.cur_light, bus.isect_dir, bus.lfsr_seed, bus.pixel_bounces} !== '0) begin
      failures++;
      $display("FAIL rstmid_regs got=%h exp=0", {bus.cur_light, bus.lfsr_seed});
    end
  endtask
  initial begin
    checks = 0;
    failures = 0;
    rst = 1;
    bus.ray_in_origin = '0;
    bus.ray_in_dir = '0;
    bus.ray_in_color = '0;
    bus.ray_in_light = '0;
    bus.ray_in_seed = '0;
    bus.ray_in_valid = 0;
    bus.isect_done = 0;
    bus.isect_hit = 0;
    bus.new_dir = '0;
    bus.new_origin = '0;
    bus.new_color = '0;
    bus.new_income_light = '0;
    bus.reflect_done = 0;
    bus.pixel_ready = 0;
    test_reset();
    test_miss();
    test_all_hits();
    test_hit_hit_miss();
    test_random();
    test_watchdog();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ray_bounce_ctrl.md
RAY_BOUNCE_CTRL -- requirements
Module: ray_bounce_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  MAX_BOUNCES, 4, maximum reflections per path (1..15).
  TIMEOUT_CYCLES, 1023, watchdog limit per wait state (1..1023).
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock.
  rst  in  1  synchronous, active-high reset.
  ray_in_origin  in  72  fp24_vec3 primary ray origin.
  ray_in_dir  in  72  fp24_vec3 primary ray direction.
  ray_in_color  in  72  fp24_color initial throughput.
  ray_in_light  in  72  fp24_color initial accumulated light.
  ray_in_seed  in  48  per-path PRNG seed.
  ray_in_valid  in  1  primary ray offered.
  ray_in_ready  out  1  controller accepts a ray.
  isect_origin  out  72  current ray origin to intersector.
  isect_dir  out  72  current ray direction to intersector.
  isect_start  out  1  one-cycle intersect request.
  isect_done  in  1  intersector result strobe.
  isect_hit  in  1  qualifies isect_done; 1 = hit, 0 = miss.
  refl_start  out  1  drives ray_reflector hit_valid.
  cur_dir  out  72  ray_dir to reflector.
  cur_color  out  72  ray_color to reflector.
  cur_light  out  72  income_light to reflector.
  lfsr_seed  out  48  reflector PRNG seed.
  new_dir  in  72  reflected direction.
  new_origin  in  72  reflected origin.
  new_color  in  72  updated throughput.
  new_income_light  in  72  updated light.
  reflect_done  in  1  reflector result strobe.
  pixel_color  out  72  final accumulated light.
  pixel_bounces  out  4  reflections completed.
  pixel_err  out  1  path ended by watchdog.
  pixel_valid  out  1  result available.
  pixel_ready  in  1  consumer accepts result.

Function
REQ-003 The FSM SHALL have states IDLE, TRACE, WAIT_ISECT, WAIT_REFLECT, OUTPUT.
REQ-004 In IDLE, ray_in_ready SHALL be 1; it SHALL be 0 in every other state.
REQ-005 In IDLE with ray_in_valid=1, the block SHALL latch origin, dir, color, light and seed into the current registers, clear bnc_cnt, clear err, and move to TRACE.
REQ-006 In TRACE, isect_start SHALL be 1 for exactly one cycle; the state SHALL then go to WAIT_ISECT.
REQ-007 isect_origin, isect_dir, cur_dir, cur_color and cur_light SHALL be the current registers, held stable outside the cycle that updates them.
REQ-008 In WAIT_ISECT with isect_done=1 and isect_hit=0 (miss), the block SHALL go to OUTPUT with cur_light unchanged.
REQ-009 In WAIT_ISECT with isect_done=1 and isect_hit=1, refl_start SHALL be 1 combinationally in that same cycle only, and the state SHALL go to WAIT_REFLECT.
REQ-010 refl_start SHALL be 0 in every other state and cycle.
REQ-011 In WAIT_REFLECT with reflect_done=1, the block SHALL load new_dir, new_origin, new_color and new_income_light into the current registers, and increment bnc_cnt.
REQ-012 After REQ-011, the state SHALL go to OUTPUT if the incremented bnc_cnt equals MAX_BOUNCES, else to TRACE.
REQ-013 isect_done and reflect_done SHALL be ignored outside WAIT_ISECT and WAIT_REFLECT respectively.
REQ-014 lfsr_seed SHALL equal the latched seed plus bnc_cnt, modulo 2^48.
REQ-015 A watchdog counter SHALL clear on entry to WAIT_ISECT or WAIT_REFLECT and increment each cycle in those states.
REQ-016 When the watchdog reaches TIMEOUT_CYCLES with no strobe, the block SHALL set err and go to OUTPUT.
REQ-017 A strobe arriving in the same cycle as watchdog expiry SHALL take priority over the timeout.
REQ-018 In OUTPUT, pixel_valid SHALL be 1, and pixel_color, pixel_bounces and pixel_err SHALL equal cur_light, bnc_cnt and err.
REQ-019 OUTPUT SHALL hold all pixel outputs until pixel_ready=1, then go to IDLE.
REQ-020 A new ray SHALL NOT be accepted in the OUTPUT cycle in which pixel_ready is high.
REQ-021 Only one path SHALL be in flight at a time; there SHALL be no buffering beyond the current registers.

Reset
REQ-022 On rst, at any state including mid-path, the state SHALL go to IDLE and all current registers, bnc_cnt, watchdog and err SHALL clear to 0.
REQ-023 On rst, all outputs SHALL be 0 except ray_in_ready, which SHALL be 1 on the first cycle after reset.
REQ-024 Strobes arriving after reset for an aborted path SHALL be ignored per REQ-013.

Verification
REQ-025 The bench SHALL cover:
  - Immediate miss: ray, light=L0, isect_done with hit=0 after 5 cycles -> pixel_color=L0, pixel_bounces=0, pixel_err=0, exactly one isect_start.
  - MAX_BOUNCES=4, all hits: 4 refl_start pulses, lfsr_seed = seed+0..3 at each refl_start -> pixel_bounces=4, pixel_color = last new_income_light.
  - Hit, hit, miss -> pixel_bounces=2; isect_dir on the third trace equals the second new_dir.
  - Watchdog: TIMEOUT_CYCLES=16, no isect_done -> OUTPUT 16 cycles after WAIT_ISECT entry, pixel_err=1; reflect_done coincident with expiry -> normal path.
  - Backpressure: pixel_ready low for 10 cycles -> outputs stable, ray_in_ready=0 throughout.
  - Reset in WAIT_REFLECT, then a late reflect_done -> IDLE, no state change, ray_in_ready=1.
